adapter_n_to_1_serializer: RTL and testbench
============================================

// Module: adapter_n_to_1_serializer
// PURPOSE
//  Parametrised parallel-to-serial adapter: captures N_INPUTS words of DATA_WIDTH
//  bits, presented as one packed bus, and emits them one word per cycle on a
//  valid/ready stream.
//  Sits between the wide packed-lane bus from the 4-to-1 lane packer and a single
//  narrow serial channel.
//  Supports back-to-back frames with no idle cycle and counts completed frames.
// PARAMETERS
//  DATA_WIDTH  16  bits per word
//  N_INPUTS    4   words per frame (>=2)
//  IDX_WIDTH   2   width of word index; must satisfy 2**IDX_WIDTH >= N_INPUTS
//  CNT_WIDTH   8   width of frame counter
// PORTS
//  clk         in   1                    rising-edge clock
//  reset_L     in   1                    synchronous reset, active-low
//  in_valid    in   1                    in_data holds a frame
//  in_ready    out  1                    block accepts a frame this cycle
//  in_data     in   N_INPUTS*DATA_WIDTH  word k at [k*DATA_WIDTH +: DATA_WIDTH]
//  out_valid   out  1                    out_data valid
//  out_ready   in   1                    sink accepts the word
//  out_data    out  DATA_WIDTH           current word
//  out_idx     out  IDX_WIDTH            index within the frame of the current word
//  out_last    out  1                    current word is the final word of its frame
//  frame_cnt   out  CNT_WIDTH            frames fully transmitted, modulo 2**CNT_WIDTH
// BEHAVIOUR
//  Reset:
//   - Sampled on clk when reset_L==0.
//   - out_valid=0, out_data=0, out_idx=0, out_last=0, frame_cnt=0; state=IDLE.
//   - Mid-frame reset discards the buffered frame; no further words are emitted.
//  Handshakes:
//   - Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
//   - in_ready is combinational: in_ready = (state==IDLE) || (out_ready && out_last).
//     Forced to 0 while reset_L==0.
//  FSM IDLE:
//   - out_valid=0.
//   - On accept: latch in_data into the frame buffer, out_idx=0, out_valid=1,
//     go to SEND.
//  FSM SEND:
//   - out_data/out_idx/out_last are held stable while out_valid && !out_ready.
//   - On a transfer with !out_last: out_idx+1, next word presented.
//   - On a transfer with out_last: frame_cnt+1 (wraps 2**CNT_WIDTH-1 -> 0).
//     - If a new accept occurs in the same cycle: load the new frame, out_idx=0,
//       stay in SEND (no bubble).
//     - Otherwise: out_valid=0, out_data=0, go to IDLE.
//  Output decode:
//   - out_last = out_valid && (out_idx == N_INPUTS-1).
//  Latency / throughput:
//   - First word is valid 1 cycle after accept.
//   - Frame throughput is N_INPUTS cycles when out_ready is held at 1.
//  Data integrity:
//   - in_data changes are ignored while in SEND, except at the back-to-back accept.
//   - No word is dropped or duplicated under any out_ready pattern.
// CONFIGURATION
//  ADAPTER_N_TO_1_SERIALIZER_MSB_FIRST_EN
//   - Defined: word at out_idx=i is word (N_INPUTS-1-i), i.e. highest lane first.
//   - Undefined: word at out_idx=i is word i, i.e. lane 0 first.
//   - Handshake, out_idx and out_last behaviour are identical in both builds.
// TESTING
//  1. Reset check: reset_L=0 for 2 cycles with in_valid=1
//     -> all outputs 0; in_ready=0; no frame accepted.
//  2. Single frame, DATA_WIDTH=16, N_INPUTS=4, in_data=64'hCDEF_89AB_4567_0123,
//     out_ready=1
//     -> 0123,4567,89AB,CDEF on 4 consecutive cycles (MSB_FIRST_EN: reversed);
//        out_last only on the 4th; frame_cnt=1.
//  3. Back-to-back: in_valid held, 2nd frame 64'h0123_00BB_0AAA_AAAA
//     -> 8 consecutive valid words with no gap; in_ready=1 only on the last-word
//        cycles; frame_cnt=2.
//  4. Backpressure: out_ready=0 for 3 cycles at out_idx=1
//     -> out_data=4567 and out_idx=1 stable; all 4 words delivered once each.
//  5. Mid-frame reset: reset_L=0 at out_idx=2
//     -> next cycle out_valid=0 and frame_cnt=0; next frame starts at out_idx=0.
//  6. Counter wrap, CNT_WIDTH=2: send 5 frames
//     -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/adapter_n_to_1_serializer.sv
// rtl/adapter_n_to_1_serializer.sv - N-to-1 word serializer with frame counter; option macro ADAPTER_N_TO_1_SERIALIZER_MSB_FIRST_EN
module adapter_n_to_1_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int N_INPUTS   = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [IDX_WIDTH-1:0]           out_idx,
    output logic                           out_last,
    output logic [CNT_WIDTH-1:0]           frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_INPUTS - 1);

    state_t                          state;
    state_t                          state_nxt;
    logic [N_INPUTS*DATA_WIDTH-1:0]  frame_buf;
    logic [IDX_WIDTH-1:0]            idx;
    logic [IDX_WIDTH-1:0]            lane;
    logic                            accept;
    logic                            xfer;

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

    // Map the position within the frame onto the buffered lane it comes from.
    always_comb begin
`ifdef ADAPTER_N_TO_1_SERIALIZER_MSB_FIRST_EN
        lane = LAST_IDX - idx;
`else
        lane = idx;
`endif
    end

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave SEND only when the last word goes out and no new frame is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (xfer && out_last && !accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: handshake decode, word select, and zeroed data while idle.
    always_comb begin
        out_valid = (state == SEND);
        out_last  = out_valid && (idx == LAST_IDX);
        in_ready  = reset_L && ((state == IDLE) || (out_ready && out_last));
        out_idx   = idx;
        out_data  = '0;
        if (out_valid) begin
            out_data = frame_buf[lane*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Datapath: frame capture, word index advance, completed-frame count.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            frame_buf <= '0;
            idx       <= '0;
            frame_cnt <= '0;
        end else begin
            if (accept) begin
                frame_buf <= in_data;
                idx       <= '0;
            end else if (xfer) begin
                idx <= out_last ? '0 : idx + 1'b1;
            end
            if (xfer && out_last) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adapter_n_to_1_serializer.sv
// tb/tb_adapter_n_to_1_serializer.sv - table, directed and randomized checks of adapter_n_to_1_serializer
module tb_adapter_n_to_1_serializer;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam logic [63:0] F1 = 64'hCDEF_89AB_4567_0123;
    localparam logic [63:0] F2 = 64'h0123_00BB_0AAA_AAAA;

    logic          clk = 1'b0;
    logic          reset_l;
    logic          in_valid;
    logic [63:0]   in_data;
    logic          out_ready;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_idx;
    logic          out_last;
    logic [7:0]    frame_cnt;

    logic          in_ready2;
    logic          out_valid2;
    logic [DW-1:0] out_data2;
    logic [1:0]    out_idx2;
    logic          out_last2;
    logic [1:0]    frame_cnt2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    adapter_n_to_1_serializer #(
        .DATA_WIDTH(DW), .N_INPUTS(N), .IDX_WIDTH(2), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .reset_L(reset_l), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .frame_cnt(frame_cnt)
    );

    adapter_n_to_1_serializer #(
        .DATA_WIDTH(DW), .N_INPUTS(N), .IDX_WIDTH(2), .CNT_WIDTH(2)
    ) dut_w (
        .clk(clk), .reset_L(reset_l), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2),
        .frame_cnt(frame_cnt2)
    );

    // word expected at position i of a frame
    function automatic logic [DW-1:0] lane_word(input logic [63:0] f, input int i);
`ifdef ADAPTER_N_TO_1_SERIALIZER_MSB_FIRST_EN
        return f[(N-1-i)*DW +: DW];
`else
        return f[i*DW +: DW];
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // reference model: queue of words still owed from the current frame
    logic [DW-1:0] mq[$];
    int            m_cnt = 0;

    always @(posedge clk) begin
        int sz;
        bit acc;
        sz = mq.size();
        if (!reset_l) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            acc = in_valid && (sz == 0 || (out_ready && sz == 1));
            if (sz > 0 && out_ready) begin
                void'(mq.pop_front());
                if (sz == 1) m_cnt++;
            end
            if (acc) begin
                for (int i = 0; i < N; i++) mq.push_back(lane_word(in_data, i));
            end
        end
    end

    task automatic check_model();
        int  sz;
        bit  e_ov;
        sz   = mq.size();
        e_ov = (sz != 0);
        chk("m_out_valid", 64'(out_valid), 64'(e_ov));
        chk("m_out_data", 64'(out_data), e_ov ? 64'(mq[0]) : 64'd0);
        if (e_ov) chk("m_out_idx", 64'(out_idx), 64'(N - sz));
        chk("m_out_last", 64'(out_last), 64'(sz == 1));
        chk("m_in_ready", 64'(in_ready), 64'(reset_l && (sz == 0 || (out_ready && sz == 1))));
        chk("m_frame_cnt", 64'(frame_cnt), 64'(m_cnt % 256));
        chk("m_frame_cnt_w", 64'(frame_cnt2), 64'(m_cnt % 4));
    endtask

    task automatic drive(input bit r, input bit iv, input logic [63:0] d, input bit ordy);
        reset_l   = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          rst_n;
        bit          iv;
        logic [63:0] din;
        bit          ordy;
        bit          e_ov;
        logic [63:0] e_frame;
        int          e_idx;
        bit          e_last;
        bit          e_ir;
        int          e_cnt;
    } vec_t;

    function automatic vec_t mk(bit r, bit iv, logic [63:0] d, bit ordy, bit ov,
                                logic [63:0] fr, int ix, bit last, bit ir, int cnt);
        vec_t v;
        v.rst_n = r; v.iv = iv; v.din = d; v.ordy = ordy; v.e_ov = ov;
        v.e_frame = fr; v.e_idx = ix; v.e_last = last; v.e_ir = ir; v.e_cnt = cnt;
        return v;
    endfunction

    vec_t          tbl[18];
    logic [DW-1:0] got[$];
    int            wrap_seq[5];

    initial begin
        tbl[0]  = mk(0, 1, F1, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, F1, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, F1, 1, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(1, 0, 0,  1, 1, F1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0,  1, 1, F1, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0,  1, 1, F1, 2, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0,  1, 1, F1, 3, 1, 1, 0);
        tbl[7]  = mk(1, 0, 0,  1, 0, 0, 0, 0, 1, 1);
        tbl[8]  = mk(1, 1, F1, 1, 0, 0, 0, 0, 1, 1);
        tbl[9]  = mk(1, 1, F2, 1, 1, F1, 0, 0, 0, 1);
        tbl[10] = mk(1, 1, F2, 1, 1, F1, 1, 0, 0, 1);
        tbl[11] = mk(1, 1, F2, 1, 1, F1, 2, 0, 0, 1);
        tbl[12] = mk(1, 1, F2, 1, 1, F1, 3, 1, 1, 1);
        tbl[13] = mk(1, 0, 0,  1, 1, F2, 0, 0, 0, 2);
        tbl[14] = mk(1, 0, 0,  1, 1, F2, 1, 0, 0, 2);
        tbl[15] = mk(1, 0, 0,  1, 1, F2, 2, 0, 0, 2);
        tbl[16] = mk(1, 0, 0,  1, 1, F2, 3, 1, 1, 2);
        tbl[17] = mk(1, 0, 0,  1, 0, 0, 0, 0, 1, 3);
        wrap_seq[0] = 1; wrap_seq[1] = 2; wrap_seq[2] = 3; wrap_seq[3] = 0; wrap_seq[4] = 1;

        reset_l = 1'b0; in_valid = 1'b1; in_data = F1; out_ready = 1'b1;
        tick();

        // reset, single frame, back-to-back
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst_n, tbl[i].iv, tbl[i].din, tbl[i].ordy);
            chk($sformatf("t%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("t%0d_out_data", i), 64'(out_data),
                tbl[i].e_ov ? 64'(lane_word(tbl[i].e_frame, tbl[i].e_idx)) : 64'd0);
            if (tbl[i].e_ov) chk($sformatf("t%0d_out_idx", i), 64'(out_idx), 64'(tbl[i].e_idx));
            chk($sformatf("t%0d_out_last", i), 64'(out_last), 64'(tbl[i].e_last));
            chk($sformatf("t%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
            chk($sformatf("t%0d_frame_cnt", i), 64'(frame_cnt), 64'(tbl[i].e_cnt));
            tick();
        end

        // backpressure at out_idx=1
        got.delete();
        drive(1, 1, F1, 1); tick();
        drive(1, 0, 0, 1);
        if (out_valid && out_ready) got.push_back(out_data);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0);
            chk("bp_hold_data", 64'(out_data), 64'(lane_word(F1, 1)));
            chk("bp_hold_idx", 64'(out_idx), 64'd1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 1);
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        drive(1, 0, 0, 1);
        chk("bp_idle_after", 64'(out_valid), 64'd0);
        tick();
        chk("bp_word_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < got.size() && k < 4; k++) begin
            chk($sformatf("bp_word%0d", k), 64'(got[k]), 64'(lane_word(F1, k)));
        end

        // mid-frame reset at out_idx=2
        drive(1, 1, F2, 1); tick();
        drive(1, 0, 0, 1); tick();
        drive(1, 0, 0, 1); tick();
        drive(0, 1, F1, 1);
        chk("mr_idx_before", 64'(out_idx), 64'd2);
        chk("mr_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        drive(1, 0, 0, 1);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_frame_cnt", 64'(frame_cnt), 64'd0);
        tick();
        drive(1, 1, F1, 1); tick();
        drive(1, 0, 0, 1);
        chk("mr_restart_idx", 64'(out_idx), 64'd0);
        chk("mr_restart_data", 64'(out_data), 64'(lane_word(F1, 0)));
        tick();
        for (int k = 0; k < 4; k++) begin drive(1, 0, 0, 1); tick(); end

        // counter wrap on the CNT_WIDTH=2 instance
        drive(0, 0, 0, 1); tick();
        for (int f = 0; f < 5; f++) begin
            drive(1, 1, {$urandom, $urandom}, 1);
            if (f > 0) chk($sformatf("wrap_cnt%0d", f - 1), 64'(frame_cnt2), 64'(wrap_seq[f - 1]));
            tick();
            for (int k = 0; k < 4; k++) begin drive(1, 0, 0, 1); tick(); end
        end
        drive(1, 0, 0, 1);
        chk("wrap_cnt4", 64'(frame_cnt2), 64'(wrap_seq[4]));
        tick();

        // randomized traffic against the queue model
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 59) != 0, $urandom_range(0, 2) != 0,
                  {$urandom, $urandom}, $urandom_range(0, 9) < 7);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
